// File: rtl/vga_fetch_ctrl_if.sv
// Signal bundle for vga_fetch_ctrl: frame control, address generator, memory read port and pixel stream.
// FETCH_DBLBUF_EN adds the second frame base input and the buffer-select output.
interface vga_fetch_ctrl_if;
    logic        start;
    logic [31:0] frame_base;
    logic        ga_en;
    logic [9:0]  ga_x;
    logic [9:0]  ga_y;
    logic [31:0] ga_offset;
    logic [31:0] ga_addr;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic [7:0]  pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        busy;
    logic        frame_done;
`ifdef FETCH_DBLBUF_EN
    logic [31:0] frame_base_b;
    logic        buf_sel;
`endif

    modport master (
        input  start, frame_base, ga_addr, mem_ack, mem_rdata, pix_ready,
        output ga_en, ga_x, ga_y, ga_offset, mem_req, mem_addr,
               pix_data, pix_valid, busy, frame_done
`ifdef FETCH_DBLBUF_EN
        , input frame_base_b
        , output buf_sel
`endif
    );

    modport slave (
        output start, frame_base, ga_addr, mem_ack, mem_rdata, pix_ready,
        input  ga_en, ga_x, ga_y, ga_offset, mem_req, mem_addr,
               pix_data, pix_valid, busy, frame_done
`ifdef FETCH_DBLBUF_EN
        , output frame_base_b
        , input buf_sel
`endif
    );
endinterface

// File: rtl/vga_fetch_ctrl.sv
// Raster-order frame fetch controller: walks (x,y), issues one memory read per pixel, buffers pixels in a FIFO.
// Optional FETCH_DBLBUF_EN: alternates the frame offset between frame_base and frame_base_b each frame.
module vga_fetch_ctrl #(
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    vga_fetch_ctrl_if.master bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [9:0]       X_LAST = 10'(H_RES - 1);
    localparam logic [9:0]       Y_LAST = 10'(V_RES - 1);
    localparam logic [CNT_W-1:0] DEPTH  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ADDR, REQ, STALL} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [9:0]       r_x;
    logic [9:0]       r_y;
    logic [31:0]      r_offset;
    logic [31:0]      r_mem_addr;
    logic [7:0]       r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_done;
    logic             w_start;
    logic             w_push;
    logic             w_pop;
    logic             w_last;
    logic             w_inflight;
    logic             w_room;
    logic [31:0]      w_base;

    assign w_start    = (r_state == IDLE) && bus.start;
    assign w_push     = (r_state == REQ) && bus.mem_ack;
    assign w_pop      = (r_count != '0) && bus.pix_ready;
    assign w_last     = (r_x == X_LAST) && (r_y == Y_LAST);
    assign w_inflight = (r_state == REQ);
    // A request is only issued when its pixel is guaranteed a FIFO slot
    assign w_room     = (r_count + CNT_W'(w_inflight)) < DEPTH;

`ifdef FETCH_DBLBUF_EN
    logic r_buf_sel;
    assign w_base      = r_buf_sel ? bus.frame_base_b : bus.frame_base;
    assign bus.buf_sel = r_buf_sel;
`else
    assign w_base      = bus.frame_base;
`endif

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_next = ADDR;
            ADDR:    w_next = w_room ? REQ : STALL;
            REQ:     if (bus.mem_ack) w_next = w_last ? IDLE : ADDR;
            STALL:   if (w_room) w_next = ADDR;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x        <= '0;
            r_y        <= '0;
            r_offset   <= '0;
            r_mem_addr <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_done     <= 1'b0;
`ifdef FETCH_DBLBUF_EN
            r_buf_sel  <= 1'b0;
`endif
        end else begin
            r_done <= w_push && w_last;
            if (w_start) begin
                r_x      <= '0;
                r_y      <= '0;
                r_offset <= w_base;
            end
            if ((r_state == ADDR) && w_room) r_mem_addr <= bus.ga_addr;
            if (w_push) begin
                // y stays on the last line after the final pixel
                if (r_x == X_LAST) begin
                    r_x <= '0;
                    if (!w_last) r_y <= r_y + 10'd1;
                end else begin
                    r_x <= r_x + 10'd1;
                end
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
            else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
`ifdef FETCH_DBLBUF_EN
            if (w_push && w_last) r_buf_sel <= ~r_buf_sel;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wr_ptr] <= bus.mem_rdata;
    end

    assign bus.ga_en      = (r_state != IDLE);
    assign bus.busy       = (r_state != IDLE);
    assign bus.ga_x       = r_x;
    assign bus.ga_y       = r_y;
    assign bus.ga_offset  = r_offset;
    assign bus.mem_req    = (r_state == REQ);
    assign bus.mem_addr   = r_mem_addr;
    assign bus.pix_data   = r_fifo[r_rd_ptr];
    assign bus.pix_valid  = (r_count != '0);
    assign bus.frame_done = r_done;
endmodule

// File: tb/tb_vga_fetch_ctrl.sv
// Directed bench for vga_fetch_ctrl (4x2 frame, 4-entry FIFO) with a per-cycle raster/FIFO model.
module tb_vga_fetch_ctrl;
    localparam int H_RES      = 4;
    localparam int V_RES      = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int NPIX       = H_RES * V_RES;

    function automatic logic [7:0] pix_fn(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic r_ack_auto  = 1'b0;
    logic r_ack_stray = 1'b0;

    vga_fetch_ctrl_if bus();

    vga_fetch_ctrl #(
        .H_RES(H_RES), .V_RES(V_RES), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    assign bus.mem_ack   = r_ack_auto | r_ack_stray;
    assign bus.mem_rdata = pix_fn(bus.mem_addr);
    assign bus.ga_addr   = bus.ga_offset + 32'(bus.ga_y) * 32'(H_RES) + 32'(bus.ga_x);

    int tests = 0;
    int fails = 0;
    int ack_delay = 0;
    int wcnt = 0;
    bit mon_on = 1'b0;

    // Model state: frame progress as a linear pixel index, FIFO as a queue
    bit          busy_m = 1'b0;
    bit          done_m = 1'b0;
    bit          bufsel_m = 1'b0;
    int          idx_m = 0;
    logic [31:0] base_m = '0;
    logic [7:0]  model_q[$];
    bit          prev_req = 1'b0;
    bit          prev_hs = 1'b0;
    logic [31:0] prev_addr = '0;
    int          cur_len = 0;
    int          n_done = 0;
    logic [31:0] hs_addr_q[$];
    logic [31:0] hs_x_q[$];
    logic [31:0] hs_y_q[$];
    int          hs_len_q[$];
    logic [7:0]  pop_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mon_step();
        bit hs, pop, was_busy;
        logic [7:0] pexp;
        if (!mon_on) return;
        hs  = bus.mem_req && bus.mem_ack && !rst;
        pop = bus.pix_valid && bus.pix_ready && !rst;
        chk("busy", 32'(bus.busy), 32'(busy_m));
        chk("ga_en", 32'(bus.ga_en), 32'(busy_m));
        chk("frame_done", 32'(bus.frame_done), 32'(done_m));
        chk("pix_valid", 32'(bus.pix_valid), 32'(model_q.size() != 0));
`ifdef FETCH_DBLBUF_EN
        chk("buf_sel", 32'(bus.buf_sel), 32'(bufsel_m));
`endif
        if (busy_m) chk("ga_offset", bus.ga_offset, base_m);
        if (bus.mem_req) cur_len++;
        if (bus.mem_req && prev_req && !prev_hs) chk("mem_addr_stable", bus.mem_addr, prev_addr);
        if (hs) begin
            chk("mem_addr", bus.mem_addr, base_m + 32'(idx_m));
            chk("ga_x", 32'(bus.ga_x), 32'(idx_m % H_RES));
            chk("ga_y", 32'(bus.ga_y), 32'(idx_m / H_RES));
            hs_addr_q.push_back(bus.mem_addr);
            hs_x_q.push_back(32'(bus.ga_x));
            hs_y_q.push_back(32'(bus.ga_y));
            hs_len_q.push_back(cur_len);
            cur_len = 0;
        end
        if (pop && model_q.size() > 0) begin
            pexp = model_q.pop_front();
            chk("pix_data", 32'(bus.pix_data), 32'(pexp));
            pop_q.push_back(bus.pix_data);
        end
        if (bus.frame_done) n_done++;
        prev_req  = bus.mem_req && !rst;
        prev_hs   = hs;
        prev_addr = bus.mem_addr;
        was_busy  = busy_m;
        done_m    = hs && (idx_m == NPIX - 1);
        if (hs) begin
            model_q.push_back(pix_fn(base_m + 32'(idx_m)));
            if (idx_m == NPIX - 1) begin
                busy_m   = 1'b0;
                idx_m    = 0;
                bufsel_m = ~bufsel_m;
            end else begin
                idx_m++;
            end
        end
        if (!was_busy && bus.start && !rst) begin
            busy_m = 1'b1;
            idx_m  = 0;
`ifdef FETCH_DBLBUF_EN
            base_m = bufsel_m ? bus.frame_base_b : bus.frame_base;
`else
            base_m = bus.frame_base;
`endif
        end
        if (rst) begin
            model_q.delete();
            busy_m   = 1'b0;
            done_m   = 1'b0;
            bufsel_m = 1'b0;
            idx_m    = 0;
            cur_len  = 0;
            prev_req = 1'b0;
        end
    endtask

    task automatic resp_step();
        if (r_ack_auto) begin
            r_ack_auto = 1'b0;
        end else if (bus.mem_req) begin
            if (wcnt >= ack_delay) begin
                r_ack_auto = 1'b1;
                wcnt = 0;
            end else begin
                wcnt++;
            end
        end
    endtask

    task automatic set_base(input logic [31:0] b);
        bus.frame_base = b;
`ifdef FETCH_DBLBUF_EN
        bus.frame_base_b = b;
`endif
    endtask

    task automatic start_pulse();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int snap;
        snap = n_done;
        for (int i = 0; i < budget && n_done == snap; i++) tick();
        chk(name, 32'(n_done - snap), 32'd1);
    endtask

    initial begin
        int s_hs, s_pop, s_done;
        bit found;
        bus.start     = 1'b0;
        bus.pix_ready = 1'b0;
        set_base('0);
        fork
            forever begin @(negedge clk); mon_step(); end
            forever begin @(posedge clk); #1; resp_step(); end
        join_none

        // Reset, with start held during reset to show rst wins
        tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_pix_valid", 32'(bus.pix_valid), 32'd0);
        chk("rst_frame_done", 32'(bus.frame_done), 32'd0);
        chk("rst_ga_en", 32'(bus.ga_en), 32'd0);
        chk("rst_ga_x", 32'(bus.ga_x), 32'd0);
        chk("rst_ga_y", 32'(bus.ga_y), 32'd0);
        chk("rst_ga_offset", bus.ga_offset, 32'd0);
        mon_on = 1'b1;
        rst = 1'b0;
        tick();

        // Full frame, immediate ack, consumer always ready
        ack_delay = 0;
        bus.pix_ready = 1'b1;
        set_base(32'h39c);
        s_hs = hs_addr_q.size(); s_pop = pop_q.size(); s_done = n_done;
        start_pulse();
        chk("s1_lat_busy", 32'(bus.busy), 32'd1);
        chk("s1_lat_noreq", 32'(bus.mem_req), 32'd0);
        tick();
        chk("s1_lat_req", 32'(bus.mem_req), 32'd1);
        wait_done(100, "s1_done_seen");
        repeat (6) tick();
        chk("s1_req_count", 32'(hs_addr_q.size() - s_hs), 32'd8);
        chk("s1_done_count", 32'(n_done - s_done), 32'd1);
        chk("s1_first_addr", hs_addr_q[s_hs], 32'h39c);
        chk("s1_x1", hs_x_q[s_hs + 1], 32'd1);
        chk("s1_y1", hs_y_q[s_hs + 1], 32'd0);
        chk("s1_x4", hs_x_q[s_hs + 4], 32'd0);
        chk("s1_y4", hs_y_q[s_hs + 4], 32'd1);
        chk("s1_last_addr", hs_addr_q[s_hs + 7], 32'h3a3);
        chk("s1_last_x", hs_x_q[s_hs + 7], 32'd3);
        chk("s1_last_y", hs_y_q[s_hs + 7], 32'd1);
        chk("s1_req_len", 32'(hs_len_q[s_hs]), 32'd1);
        chk("s1_first_pix", 32'(pop_q[s_pop]), 32'hc5);
        chk("s1_drained", 32'(bus.pix_valid), 32'd0);

        // Consumer stalled: FIFO fills, then one pop admits exactly one more request
        bus.pix_ready = 1'b0;
        set_base(32'h100);
        s_hs = hs_addr_q.size();
        start_pulse();
        repeat (40) tick();
        chk("s2_req_count_full", 32'(hs_addr_q.size() - s_hs), 32'd4);
        chk("s2_stall_noreq", 32'(bus.mem_req), 32'd0);
        chk("s2_stall_busy", 32'(bus.busy), 32'd1);
        r_ack_stray = 1'b1;
        tick();
        r_ack_stray = 1'b0;
        repeat (5) tick();
        chk("s2_stray_noreq", 32'(hs_addr_q.size() - s_hs), 32'd4);
        bus.pix_ready = 1'b1;
        tick();
        bus.pix_ready = 1'b0;
        repeat (20) tick();
        chk("s2_req_count_pop1", 32'(hs_addr_q.size() - s_hs), 32'd5);
        chk("s2_stall_again", 32'(bus.mem_req), 32'd0);
        bus.pix_ready = 1'b1;
        wait_done(200, "s2_done_seen");
        chk("s2_req_total", 32'(hs_addr_q.size() - s_hs), 32'd8);
        repeat (6) tick();

        // Slow memory: ack five cycles late; stray ack while idle
        ack_delay = 5;
        set_base(32'h200);
        s_hs = hs_addr_q.size();
        start_pulse();
        wait_done(300, "s3_done_seen");
        chk("s3_req_count", 32'(hs_addr_q.size() - s_hs), 32'd8);
        chk("s3_req_len", 32'(hs_len_q[s_hs]), 32'd6);
        chk("s3_first_addr", hs_addr_q[s_hs], 32'h200);
        ack_delay = 0;
        repeat (6) tick();
        r_ack_stray = 1'b1;
        tick();
        r_ack_stray = 1'b0;
        repeat (3) tick();
        chk("s3_stray_idle", 32'(bus.pix_valid), 32'd0);

        // Reset on the third request, then restart
        set_base(32'h480);
        s_hs = hs_addr_q.size();
        start_pulse();
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus.mem_req && (hs_addr_q.size() - s_hs) == 2) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("s4_third_req_seen", 32'(found), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("s4_rst_busy", 32'(bus.busy), 32'd0);
        chk("s4_rst_req", 32'(bus.mem_req), 32'd0);
        chk("s4_rst_valid", 32'(bus.pix_valid), 32'd0);
        r_ack_stray = 1'b1;
        tick();
        r_ack_stray = 1'b0;
        repeat (3) tick();
        chk("s4_late_ack", 32'(bus.pix_valid), 32'd0);
        set_base(32'h500);
        s_hs = hs_addr_q.size();
        start_pulse();
        wait_done(100, "s4_done_seen");
        chk("s4_restart_addr", hs_addr_q[s_hs], 32'h500);
        chk("s4_restart_x", hs_x_q[s_hs], 32'd0);
        chk("s4_restart_y", hs_y_q[s_hs], 32'd0);
        chk("s4_req_count", 32'(hs_addr_q.size() - s_hs), 32'd8);
        repeat (6) tick();

        // start while busy, with frame_base changed, must not disturb the frame
        set_base(32'h600);
        s_hs = hs_addr_q.size(); s_done = n_done;
        start_pulse();
        repeat (4) tick();
        set_base(32'h700);
        start_pulse();
        wait_done(100, "s5_done_seen");
        repeat (6) tick();
        chk("s5_req_count", 32'(hs_addr_q.size() - s_hs), 32'd8);
        chk("s5_done_count", 32'(n_done - s_done), 32'd1);
        chk("s5_first_addr", hs_addr_q[s_hs], 32'h600);
        chk("s5_last_addr", hs_addr_q[s_hs + 7], 32'h607);
        chk("s5_idle", 32'(bus.busy), 32'd0);

`ifdef FETCH_DBLBUF_EN
        // Two frames alternate between the two bases
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.frame_base   = 32'h1000;
        bus.frame_base_b = 32'h2000;
        chk("s6_bufsel_rst", 32'(bus.buf_sel), 32'd0);
        s_hs = hs_addr_q.size();
        start_pulse();
        wait_done(100, "s6_done1_seen");
        chk("s6_frame1_addr", hs_addr_q[s_hs], 32'h1000);
        chk("s6_bufsel_1", 32'(bus.buf_sel), 32'd1);
        s_hs = hs_addr_q.size();
        start_pulse();
        wait_done(100, "s6_done2_seen");
        chk("s6_frame2_addr", hs_addr_q[s_hs], 32'h2000);
        chk("s6_bufsel_2", 32'(bus.buf_sel), 32'd0);
        repeat (6) tick();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
